// File: rtl/alu_pkg.sv
// Shared opcode encodings and types for the two-stage ALU.
// Reserved codes 0010..0111 have no entry here and produce a zero result.
package alu_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_ADD = 4'b0000;
    localparam opcode_t OP_SUB = 4'b0001;
    localparam opcode_t OP_AND = 4'b1000;
    localparam opcode_t OP_OR  = 4'b1001;
    localparam opcode_t OP_XOR = 4'b1010;
    localparam opcode_t OP_NOT = 4'b1011;
    localparam opcode_t OP_SHR = 4'b1100;
    localparam opcode_t OP_SHL = 4'b1101;
    localparam opcode_t OP_ROR = 4'b1110;
    localparam opcode_t OP_ROL = 4'b1111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result = f(opcode, ina, inb), truncated to WIDTH.
// Carries, borrows and flags are dropped.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  opcode_t            c,
    input  logic [WIDTH-1:0]   ina,
    input  logic [WIDTH-1:0]   inb,
    output logic [WIDTH-1:0]   res
);

    always_comb begin
        res = '0;
        case (c)
            OP_ADD:  res = ina + inb;
            OP_SUB:  res = ina - inb;
            OP_AND:  res = ina & inb;
            OP_OR:   res = ina | inb;
            OP_XOR:  res = ina ^ inb;
            OP_NOT:  res = ~ina;
            OP_SHR:  res = ina >> 1;
            OP_SHL:  res = ina << 1;
            OP_ROR:  res = {ina[0], ina[WIDTH-1:1]};
            OP_ROL:  res = {ina[WIDTH-2:0], ina[WIDTH-1]};
            // Reserved codes yield zero so nothing undefined reaches the output.
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Two-stage registered ALU: operands/opcode are registered, then the
// combinational core result is registered onto o. One operation per cycle.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] o,
    input  opcode_t          ctr,
    input  logic             ck,
    input  logic             rst
);

    logic [WIDTH-1:0] ina_q, inb_q;
    opcode_t          c_q;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] o_q;

    always_ff @(posedge ck) begin
        if (rst) begin
            ina_q <= '0;
            inb_q <= '0;
            c_q   <= OP_ADD;
        end else begin
            ina_q <= a;
            inb_q <= b;
            c_q   <= ctr;
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .c   (c_q),
        .ina (ina_q),
        .inb (inb_q),
        .res (res)
    );

    // Cleared input stage decodes as 0+0, so o stays zero one edge past reset.
    always_ff @(posedge ck) begin
        if (rst) begin
            o_q <= '0;
        end else begin
            o_q <= res;
        end
    end

    assign o = o_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver pushes the expected o for every edge,
// a negedge monitor pops and compares against the DUT output.
module tb_alu;

    logic [7:0] a, b, o;
    logic [3:0] ctr;
    logic       ck, rst;

    alu #(
        .WIDTH (8)
    ) dut (
        .a   (a),
        .b   (b),
        .o   (o),
        .ctr (ctr),
        .ck  (ck),
        .rst (rst)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cycles = 0;
    bit         done   = 1'b0;

    // Bench-side model state: what the DUT sampled on the previous edge.
    bit         started   = 1'b0;
    bit         prev_rst  = 1'b1;
    int         prev_a    = 0;
    int         prev_b    = 0;
    int         prev_c    = 0;

    function automatic int ref_op(input int op, input int x, input int y);
        case (op)
            0:       return (x + y) % 256;
            1:       return (x - y + 256) % 256;
            8:       return x & y;
            9:       return x | y;
            10:      return x ^ y;
            11:      return 255 - x;
            12:      return x / 2;
            13:      return (x * 2) % 256;
            14:      return x / 2 + (x % 2) * 128;
            15:      return (x * 2) % 256 + x / 128;
            default: return 0;
        endcase
    endfunction

    // Apply inputs, wait for the sampling edge, then record what o must show after it.
    task automatic step(input bit r, input int av, input int bv, input int cv);
        int e;
        rst = r;
        a   = 8'(av);
        b   = 8'(bv);
        ctr = 4'(cv);
        @(posedge ck);
        if (r || prev_rst) e = 0;
        else               e = ref_op(prev_c, prev_a, prev_b);
        if (r) started = 1'b1;
        if (started) exp_q.push_back(8'(e));
        prev_rst = r;
        prev_a   = av;
        prev_b   = bv;
        prev_c   = cv;
        #1;
    endtask

    initial begin
        rst = 1'b1; a = 8'hFF; b = 8'hFF; ctr = 4'h0;
        step(1, 'hFF, 'hFF, 0);
        step(1, 'hFF, 'hFF, 0);
        step(0, 'hF0, 'h20, 0);
        step(0, 'h05, 'h07, 1);
        for (int op = 8; op <= 11; op++) step(0, 'hCA, 'hA6, op);
        for (int op = 12; op <= 15; op++) step(0, 'h81, int'($urandom_range(0, 255)), op);
        for (int op = 2; op <= 7; op++) begin
            step(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), op);
        end
        for (int i = 0; i < 50; i++) begin
            step((i == 25) || ($urandom_range(0, 19) == 0),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 15)));
        end
        step(0, 0, 0, 0);
        repeat (3) @(posedge ck);
        done = 1'b1;
    end

    always @(negedge ck) begin
        cycles++;
        if (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL o_result t=%0t: got %h expected %h", $time, o, e);
            end
        end
        if (done || cycles > 2000) begin
            checks++;
            if (!done || exp_q.size() != 0 || checks < 13) begin
                errors++;
                $display("FAIL drain: done=%0d pending=%0d checks=%0d required done=1 pending=0",
                         done, exp_q.size(), checks);
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

endmodule
